// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the write-port arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned ZERO_REG_DEFAULT = 31;
  localparam int unsigned DATA_W_DEFAULT   = 64;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grantIdx,
  output logic             anyGrant
);

  int unsigned pos;

  // Walk the requests starting at ptr; the first valid one wins.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    pos      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!anyGrant && req[IDX_W'(pos)]) begin
        grant[IDX_W'(pos)] = 1'b1;
        grantIdx           = IDX_W'(pos);
        anyGrant           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ writers.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NREQ-1:0]                     req_valid,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]     req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]         req_data,
  output logic [NREQ-1:0]                     req_ready,
  input  logic                                hold,
  output logic [REG_ADDR_W-1:0]               WriteRegister,
  output logic [DATA_W-1:0]                   WriteData,
  output logic                                RegWrite,
  output logic [$clog2(NREQ)-1:0]             last_grant,
  output logic                                dropped
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr;
  logic [NREQ-1:0]  pickGrant;
  logic [IDX_W-1:0] pickIdx;
  logic             pickAny;
  logic             accept;
  logic             isZero;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) picker (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (pickGrant),
    .grantIdx (pickIdx),
    .anyGrant (pickAny)
  );

  // Grant is suppressed while held or in reset; a grant on a valid line is an accept.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    isZero    = (req_addr[pickIdx] == REG_ADDR_W'(ZERO_REG));
    if (reset_n && !hold && pickAny) begin
      req_ready = pickGrant;
      accept    = 1'b1;
    end
  end

  // Pointer, last grant and the registered write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      last_grant    <= '0;
      WriteRegister <= '0;
      WriteData     <= '0;
      RegWrite      <= 1'b0;
      dropped       <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      dropped  <= 1'b0;
      if (accept) begin
        ptr           <= (pickIdx == IDX_W'(NREQ - 1)) ? '0 : pickIdx + IDX_W'(1);
        last_grant    <= pickIdx;
        WriteRegister <= req_addr[pickIdx];
        WriteData     <= req_data[pickIdx];
        RegWrite      <= !isZero;
        dropped       <= isZero;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table, corner sequences, random traffic.
module tb_regfile_write_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ZERO_REG = 31;
  localparam int unsigned IDX_W    = 2;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic                          hold;
  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0]               req_ready;
  logic [NREQ-1:0][4:0]          req_addr;
  logic [NREQ-1:0][DATA_W-1:0]   req_data;
  logic [4:0]                    WriteRegister;
  logic [DATA_W-1:0]             WriteData;
  logic                          RegWrite;
  logic [IDX_W-1:0]              last_grant;
  logic                          dropped;

  regfile_write_arbiter #(
    .NREQ     (NREQ),
    .DATA_W   (DATA_W),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .hold          (hold),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .last_grant    (last_grant),
    .dropped       (dropped)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: priority pointer plus the expected write-port registers.
  int          mPtr;
  int          mLast;
  logic [4:0]  mWr;
  logic [63:0] mWd;
  logic        mRw;
  logic        mDrop;

  task automatic modelReset();
    mPtr = 0; mLast = 0; mWr = '0; mWd = '0; mRw = 1'b0; mDrop = 1'b0;
  endtask

  function automatic int modelPick(input logic [NREQ-1:0] v, input logic h);
    int j;
    if (h) return -1;
    for (int k = 0; k < int'(NREQ); k++) begin
      j = (mPtr + k) % int'(NREQ);
      if (v[IDX_W'(j)]) return j;
    end
    return -1;
  endfunction

  // Called at a negedge: check all outputs against the model, then step through the posedge.
  task automatic cycle(output int acc);
    int exp;
    logic [NREQ-1:0] expReady;
    exp = modelPick(req_valid, hold);
    expReady = '0;
    if (exp >= 0) expReady[IDX_W'(exp)] = 1'b1;
    chk("m_ready", 64'(req_ready), 64'(expReady));
    chk("m_regwrite", 64'(RegWrite), 64'(mRw));
    chk("m_wreg", 64'(WriteRegister), 64'(mWr));
    chk("m_wdata", 64'(WriteData), mWd);
    chk("m_last", 64'(last_grant), 64'(mLast));
    chk("m_dropped", 64'(dropped), 64'(mDrop));
    @(posedge clk);
    mRw = 1'b0;
    mDrop = 1'b0;
    if (exp >= 0) begin
      mWr   = req_addr[exp];
      mWd   = req_data[exp];
      mRw   = (req_addr[exp] != 5'(ZERO_REG));
      mDrop = (req_addr[exp] == 5'(ZERO_REG));
      mLast = exp;
      mPtr  = (exp + 1) % int'(NREQ);
    end
    acc = exp;
    #1;
  endtask

  // Requester contract: a pending, un-granted request stays valid with stable payload.
  logic                         contractOn = 1'b0;
  logic [NREQ-1:0]              pv = '0;
  logic [NREQ-1:0]              pr = '0;
  logic [NREQ-1:0][4:0]         pa;
  logic [NREQ-1:0][DATA_W-1:0]  pd;

  always @(posedge clk) begin
    if (contractOn && reset_n) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (pv[i] && !pr[i])
          chk("contract", 64'(req_valid[i] && req_addr[i] == pa[i] && req_data[i] == pd[i]), 64'(1));
      end
    end
    pv <= req_valid;
    pr <= req_ready;
    pa <= req_addr;
    pd <= req_data;
  end

  typedef struct {
    logic [3:0] valid;
    logic       hold;
    logic [4:0] a2;
    logic [3:0] eReady;
    logic       eRw;
    logic [4:0] eWr;
    logic [1:0] eLast;
    logic       eDrop;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int acc;

    tbl[0]  = '{4'b1111, 1'b0, 5'd3,  4'b0001, 1'b0, 5'd0,  2'd0, 1'b0};
    tbl[1]  = '{4'b1111, 1'b0, 5'd3,  4'b0010, 1'b1, 5'd1,  2'd0, 1'b0};
    tbl[2]  = '{4'b1111, 1'b0, 5'd3,  4'b0100, 1'b1, 5'd2,  2'd1, 1'b0};
    tbl[3]  = '{4'b1111, 1'b0, 5'd3,  4'b1000, 1'b1, 5'd3,  2'd2, 1'b0};
    tbl[4]  = '{4'b1111, 1'b0, 5'd3,  4'b0001, 1'b1, 5'd4,  2'd3, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 5'd3,  4'b0000, 1'b1, 5'd1,  2'd0, 1'b0};
    tbl[6]  = '{4'b0000, 1'b0, 5'd3,  4'b0000, 1'b0, 5'd1,  2'd0, 1'b0};
    tbl[7]  = '{4'b0100, 1'b0, 5'd31, 4'b0100, 1'b0, 5'd1,  2'd0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 5'd31, 4'b0000, 1'b0, 5'd31, 2'd2, 1'b1};
    tbl[9]  = '{4'b1000, 1'b0, 5'd3,  4'b1000, 1'b0, 5'd31, 2'd2, 1'b0};
    tbl[10] = '{4'b0000, 1'b0, 5'd3,  4'b0000, 1'b1, 5'd4,  2'd3, 1'b0};
    tbl[11] = '{4'b1010, 1'b1, 5'd3,  4'b0000, 1'b0, 5'd4,  2'd3, 1'b0};
    tbl[12] = '{4'b1010, 1'b1, 5'd3,  4'b0000, 1'b0, 5'd4,  2'd3, 1'b0};
    tbl[13] = '{4'b1010, 1'b1, 5'd3,  4'b0000, 1'b0, 5'd4,  2'd3, 1'b0};
    tbl[14] = '{4'b1010, 1'b0, 5'd3,  4'b0010, 1'b0, 5'd4,  2'd3, 1'b0};
    tbl[15] = '{4'b1000, 1'b0, 5'd3,  4'b1000, 1'b1, 5'd2,  2'd1, 1'b0};
    tbl[16] = '{4'b1001, 1'b0, 5'd3,  4'b0001, 1'b1, 5'd4,  2'd3, 1'b0};
    tbl[17] = '{4'b1000, 1'b0, 5'd3,  4'b1000, 1'b1, 5'd1,  2'd0, 1'b0};
    tbl[18] = '{4'b0000, 1'b0, 5'd3,  4'b0000, 1'b1, 5'd4,  2'd3, 1'b0};
    tbl[19] = '{4'b0000, 1'b0, 5'd3,  4'b0000, 1'b0, 5'd4,  2'd3, 1'b0};

    // Reset held with every requester valid.
    reset_n   = 1'b0;
    hold      = 1'b0;
    req_valid = '1;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_addr[i] = 5'(i + 1);
      req_data[i] = 64'(32'hA + 32'(i));
    end
    modelReset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_regwrite", 64'(RegWrite), 64'(0));
    chk("rst_wreg", 64'(WriteRegister), 64'(0));
    chk("rst_dropped", 64'(dropped), 64'(0));
    chk("rst_last", 64'(last_grant), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Directed vector table: round-robin, zero register, hold, pointer wrap.
    for (int r = 0; r < 20; r++) begin
      req_valid   = tbl[r].valid;
      hold        = tbl[r].hold;
      req_addr[2] = tbl[r].a2;
      req_data[2] = (tbl[r].a2 == 5'd31) ? 64'hFFFF : 64'hC;
      @(negedge clk);
      chk("t_ready", 64'(req_ready), 64'(tbl[r].eReady));
      chk("t_regwrite", 64'(RegWrite), 64'(tbl[r].eRw));
      chk("t_wreg", 64'(WriteRegister), 64'(tbl[r].eWr));
      chk("t_last", 64'(last_grant), 64'(tbl[r].eLast));
      chk("t_dropped", 64'(dropped), 64'(tbl[r].eDrop));
      cycle(acc);
    end

    // Hold rising right after an accept: that write still pulses RegWrite.
    req_valid = 4'b0011;
    hold      = 1'b0;
    @(negedge clk); cycle(acc);
    req_valid[0] = 1'b0;
    hold = 1'b1;
    @(negedge clk);
    chk("hold_pulse", 64'(RegWrite), 64'(1));
    cycle(acc);
    @(negedge clk); cycle(acc);
    hold = 1'b0;
    @(negedge clk); cycle(acc);
    req_valid = '0;
    @(negedge clk); cycle(acc);

    // Mid-operation reset discards the registered write to r5.
    req_valid   = 4'b0001;
    req_addr[0] = 5'd5;
    @(negedge clk); cycle(acc);
    chk("mid_acc_pulse", 64'(RegWrite), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_regwrite", 64'(RegWrite), 64'(0));
    chk("mid_wreg", 64'(WriteRegister), 64'(0));
    chk("mid_ready", 64'(req_ready), 64'(0));
    modelReset();
    @(negedge clk);
    chk("mid_ready_hold", 64'(req_ready), 64'(0));
    chk("mid_regwrite_hold", 64'(RegWrite), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk); cycle(acc);
    if (acc >= 0) req_valid[acc] = 1'b0;
    @(negedge clk); cycle(acc);

    // Randomized traffic checked against the model, with the contract monitor on.
    contractOn = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!req_valid[i] && ($urandom % 2 == 0)) begin
          req_valid[i] = 1'b1;
          req_addr[i]  = ($urandom % 4 == 0) ? 5'd31 : 5'($urandom % 32);
          req_data[i]  = {$urandom, $urandom};
        end
      end
      hold = ($urandom % 4 == 0);
      @(negedge clk);
      cycle(acc);
      if (acc >= 0) req_valid[acc] = 1'b0;
    end
    contractOn = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between NREQ writeback requesters, such as the ALU, the load unit and the link/branch unit. It uses round-robin arbitration with a valid/ready handshake per requester. The winning request is registered onto the write port signals WriteRegister, WriteData and RegWrite, which feed the register file's write-enable decode. Writes to the hardwired zero register are accepted but suppressed.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 64, write data width
ZERO_REG, 31, register index that is read-as-zero; writes to it are dropped

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  requester i has a write pending
req_addr  input  NREQ x 5  destination register per requester
req_data  input  NREQ x DATA_W  write data per requester
req_ready  output  NREQ  one-hot grant; a handshake completes when valid & ready
hold  input  1  when 1, no grant is issued (register file busy or frozen)
WriteRegister  output  5  registered write address
WriteData  output  DATA_W  registered write data
RegWrite  output  1  registered write enable, one-cycle pulse per accepted non-zero-register write
last_grant  output  $clog2(NREQ)  index of the most recently accepted requester
dropped  output  1  one-cycle pulse when an accepted write targeted ZERO_REG

Behaviour:
- Reset (asynchronous, reset_n=0):
  - RegWrite=0, WriteRegister=0, WriteData=0, dropped=0, last_grant=0.
  - Priority pointer = 0, so requester 0 has highest priority.
  - req_ready is all-zero for as long as reset_n=0.
- Grant logic (combinational from req_valid, pointer and hold):
  - Search from index ptr upward, wrapping modulo NREQ. The first i with req_valid[i]=1 gets req_ready[i]=1.
  - At most one bit of req_ready is set.
  - hold=1 or no valid request gives req_ready=0.
- Pointer update:
  - On an accept by requester i: ptr <= (i+1) mod NREQ and last_grant <= i.
  - With no accept, ptr and last_grant hold their value.
- Write port, one cycle of latency after the accept edge:
  - WriteRegister <= req_addr[i] and WriteData <= req_data[i].
  - RegWrite <= (req_addr[i] != ZERO_REG).
  - dropped <= (req_addr[i] == ZERO_REG).
- With no accept in a cycle:
  - RegWrite <= 0 and dropped <= 0.
  - WriteRegister and WriteData hold their last value.
- Throughput: one write per cycle sustained. Back-to-back accepts from different or the same requesters produce back-to-back RegWrite pulses.
- Requester contract:
  - Once req_valid[i] is raised, it stays high with stable addr and data until accepted.
  - The arbiter does not check this contract; the bench asserts it.
- A single requester that is continuously valid is granted every cycle, because the pointer wraps back to it.
- hold rises while requests are pending: grants stop in that same cycle. A write accepted on the previous edge still completes its RegWrite pulse.
- reset_n asserted mid-operation: a pending registered write is discarded (RegWrite forced to 0 immediately). Requests still valid after reset are re-arbitrated from ptr=0.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive cycles.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W = 5 and NUM_REGS = 32
  - ZERO_REG default = 31
  - DATA_W default = 64
- Natural sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector and ptr. Outputs: one-hot grant and the encoded index.
  - The arbiter instantiates it once and owns all state: ptr, last_grant and the output registers.

Test Plan:
- Reset: hold reset_n=0 with all req_valid=1 -> req_ready=0000, RegWrite=0, WriteRegister=0. Release reset -> first grant is req0, and the next cycle shows RegWrite=1 with WriteRegister=req_addr[0].
- Round-robin: all 4 requesters valid with addrs 1, 2, 3, 4 and data 0xA..0xD -> grants 0,1,2,3,0,... on successive cycles; WriteRegister sequence 1,2,3,4,1 one cycle later; last_grant follows 0,1,2,3.
- Zero register: req2 valid with addr=31, data=0xFFFF -> req_ready[2]=1, next cycle RegWrite=0, dropped=1, last_grant=2.
- Hold: req1 and req3 valid, hold=1 for 3 cycles -> req_ready=0 and RegWrite=0 throughout. After hold drops -> req1 is granted first (ptr=0 search), then req3.
- Pointer wrap: after req3 is accepted (ptr=0), req0 and req3 are valid -> req0 is granted before req3.
- Mid-operation reset: accept req0 with addr=5, then drop reset_n before the next edge -> RegWrite stays 0 and no write to register 5 appears.
